// File: rtl/ds1302_serial_access.sv
// DS1302 three-wire bit engine: one Start/Done access = CE setup, 16 SCLK pulses, CE hold, CE recovery.
// Latency: Done_Sig rises 2*T_CE + 32*T_HALF + 1 CLK cycles after the IDLE cycle that accepted Start_Sig.
// Backpressure: none; Start_Sig is only sampled in IDLE, and changes later in the access are ignored.
// Optional build macro DS1302_SIO_SPLIT_EN: replaces inout DS_SIO with DS_SIO_O / DS_SIO_OE / DS_SIO_I.
`timescale 1ns/1ps

module ds1302_serial_access #(
  parameter int T_HALF = 50,   // CLK cycles per SCLK half-period (>= 2)
  parameter int T_CE   = 200,  // CE setup before first rise and CE hold after last fall (>= 1)
  parameter int T_CWH  = 200   // CE low recovery time between accesses (>= 1)
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [1:0] Start_Sig,
  input  logic [7:0] Words_Addr,
  input  logic [7:0] Write_Data,
  output logic       Done_Sig,
  output logic [7:0] Read_Data,
  output logic       DS_RST,
  output logic       DS_SCLK,
`ifdef DS1302_SIO_SPLIT_EN
  output logic       DS_SIO_O,
  output logic       DS_SIO_OE,
  input  logic       DS_SIO_I
`else
  inout  wire        DS_SIO
`endif
);

  // One counter serves every timed phase, so size it for the longest one.
  localparam int MAX_A = (2 * T_HALF > T_CE) ? 2 * T_HALF : T_CE;
  localparam int MAX_C = (MAX_A > T_CWH) ? MAX_A : T_CWH;
  localparam int CW    = (MAX_C > 2) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] CE_LAST   = CW'(T_CE - 1);
  localparam logic [CW-1:0] CWH_LAST  = CW'(T_CWH - 1);
  localparam logic [CW-1:0] LOW_LAST  = CW'(T_HALF - 1);
  localparam logic [CW-1:0] HIGH_LAST = CW'(2 * T_HALF - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CE_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CE_HOLD  = 3'd3,
    DONE     = 3'd4,
    RECOVER  = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [3:0]    next_bit;
  logic [7:0]    addr_q;
  logic [7:0]    data_q;
  logic          is_read;
  logic [7:0]    shreg;
  logic          sio_o;
  logic          sio_oe;
  logic          sio_i;

  // Pad-side connection of the data line: either exported as separate signals or an internal tri-state.
`ifdef DS1302_SIO_SPLIT_EN
  assign DS_SIO_O  = sio_o;
  assign DS_SIO_OE = sio_oe;
  assign sio_i     = DS_SIO_I;
`else
  assign DS_SIO = sio_oe ? sio_o : 1'bz;
  assign sio_i  = DS_SIO;
`endif

  // Index of the bit that the upcoming SCLK pulse will carry.
  always_comb begin
    next_bit = bit_idx + 4'd1;
  end

  // Transaction sequencer; every bus pin and Done_Sig is a register so the pins never glitch.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 4'd0;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      is_read   <= 1'b0;
      shreg     <= 8'h00;
      sio_o     <= 1'b0;
      sio_oe    <= 1'b0;
      Done_Sig  <= 1'b0;
      Read_Data <= 8'h00;
      DS_RST    <= 1'b0;
      DS_SCLK   <= 1'b0;
    end else begin
      Done_Sig <= 1'b0;
      case (state)
        IDLE: begin
          // 2'b11 is not a legal request and is dropped here like 2'b00.
          if (Start_Sig == 2'b10 || Start_Sig == 2'b01) begin
            addr_q  <= Words_Addr;
            data_q  <= Write_Data;
            is_read <= (Start_Sig == 2'b01);
            DS_RST  <= 1'b1;
            cnt     <= '0;
            state   <= CE_SETUP;
          end
        end

        CE_SETUP: begin
          if (cnt == CE_LAST) begin
            // Present address bit 0 at the start of the low phase so it is valid for the whole pulse.
            cnt     <= '0;
            bit_idx <= 4'd0;
            sio_oe  <= 1'b1;
            sio_o   <= addr_q[0];
            state   <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (cnt == LOW_LAST) begin
            // Last CLK of the low phase: raise SCLK; on reads this is also the sample point.
            DS_SCLK <= 1'b1;
            cnt     <= cnt + 1'b1;
            if (is_read && bit_idx[3]) begin
              shreg <= {sio_i, shreg[7:1]};
            end
          end else if (cnt == HIGH_LAST) begin
            // Falling edge ends the pulse and sets up the next bit.
            DS_SCLK <= 1'b0;
            cnt     <= '0;
            if (bit_idx == 4'd15) begin
              sio_oe <= 1'b0;
              state  <= CE_HOLD;
            end else begin
              bit_idx <= next_bit;
              if (!next_bit[3]) begin
                sio_o <= addr_q[next_bit[2:0]];
              end else if (!is_read) begin
                sio_o <= data_q[next_bit[2:0]];
              end else begin
                // Hand the line to the DS1302 on the fall that ends address pulse 7.
                sio_oe <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        CE_HOLD: begin
          if (cnt == CE_LAST) begin
            DS_RST   <= 1'b0;
            sio_oe   <= 1'b0;
            Done_Sig <= 1'b1;
            if (is_read) begin
              Read_Data <= shreg;
            end
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          cnt   <= '0;
          state <= RECOVER;
        end

        RECOVER: begin
          // CE stays low long enough for the DS1302 before the next request is looked at.
          if (cnt == CWH_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ds1302_serial_access.sv
// Self-checking bench for ds1302_serial_access with a behavioural DS1302 slave on the data line.
// Table of directed accesses plus hand-written sequences: illegal request, mid-access reset, back-to-back.
`timescale 1ns/1ps

module tb_ds1302_serial_access;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic [1:0] Start_Sig = 2'b00;
  logic [7:0] Words_Addr = 8'h00;
  logic [7:0] Write_Data = 8'h00;
  logic       Done_Sig;
  logic [7:0] Read_Data;
  logic       DS_RST;
  logic       DS_SCLK;
  wire        DS_SIO;

  ds1302_serial_access #(.T_HALF(2), .T_CE(4), .T_CWH(4)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .Start_Sig  (Start_Sig),
    .Words_Addr (Words_Addr),
    .Write_Data (Write_Data),
    .Done_Sig   (Done_Sig),
    .Read_Data  (Read_Data),
    .DS_RST     (DS_RST),
    .DS_SCLK    (DS_SCLK),
    .DS_SIO     (DS_SIO)
  );

  always #5 CLK = ~CLK;

  // Slave model: drives read data on falling SCLK edges 8..15, releases after.
  logic       s_oe = 1'b0;
  logic       s_o = 1'b0;
  logic       s_prev = 1'b0;
  logic       slave_en = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  int         s_fall = 0;
  int         contention = 0;
  int         zviol = 0;

  assign DS_SIO = s_oe ? s_o : 1'bz;

  always @(negedge CLK) begin
    if (s_oe && DS_SIO !== s_o) contention++;
    if (!s_oe && !DS_RST && DS_SIO !== 1'bz) zviol++;
    if (!DS_RST) begin
      s_fall = 0;
      s_oe   = 1'b0;
    end else if (s_prev && !DS_SCLK) begin
      s_fall++;
      if (slave_en && s_fall >= 8 && s_fall <= 15) begin
        s_oe = 1'b1;
        s_o  = slave_byte[s_fall-8];
      end else begin
        s_oe = 1'b0;
      end
    end
    s_prev = DS_SCLK;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  dir;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  sbyte;
    int          hold;      // 0: hold Start until Done, N: drop after N cycles
    logic [15:0] exp_bits;  // SIO at rising SCLK edges, bit i = pulse i
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vt[6];

  task automatic run_txn(input vec_t v, input int idx);
    int cyc, rst_hi, nr, lat;
    logic [15:0] bits;
    logic prev;
    bit seen;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge CLK);
    slave_en   = (v.dir == 2'b01);
    slave_byte = v.sbyte;
    contention = 0;
    Start_Sig  = v.dir;
    Words_Addr = v.addr;
    Write_Data = v.wdata;
    cyc = 0; rst_hi = 0; nr = 0; bits = 16'h0; prev = DS_SCLK; seen = 0; lat = -1;
    while (!seen && cyc < 400) begin
      @(negedge CLK);
      cyc++;
      if (v.hold != 0 && cyc == v.hold) begin
        Start_Sig  = 2'b00;
        Words_Addr = 8'hFF;
        Write_Data = 8'hFF;
      end
      if (DS_RST) rst_hi++;
      if (DS_SCLK && !prev) begin
        if (nr < 16) bits[nr] = DS_SIO;
        nr++;
      end
      prev = DS_SCLK;
      if (Done_Sig) begin
        seen = 1;
        lat  = cyc;
      end
    end
    Start_Sig = 2'b00;
    check({tag, "_latency"}, lat, 73);
    check({tag, "_ce_high_cycles"}, rst_hi, 72);
    check({tag, "_sclk_pulses"}, nr, 16);
    check({tag, "_sio_bits"}, {16'h0, bits}, {16'h0, v.exp_bits});
    check({tag, "_read_data"}, {24'h0, Read_Data}, {24'h0, v.exp_rd});
    @(negedge CLK);
    check({tag, "_done_width"}, {31'h0, Done_Sig}, 32'h0);
    check({tag, "_contention"}, contention, 0);
    repeat (10) @(negedge CLK);
  endtask

  initial begin
    int cyc, nr, lo, dn, hi;
    logic prev;
    bit seen;

    //          dir    addr   wdata  sbyte  hold bits      rd
    vt[0] = '{2'b10, 8'h84, 8'h23, 8'h00, 0, 16'h2384, 8'h00};
    vt[1] = '{2'b01, 8'h81, 8'h00, 8'h59, 0, 16'h5981, 8'h59};
    vt[2] = '{2'b10, 8'h8E, 8'h80, 8'h00, 3, 16'h808E, 8'h59};
    vt[3] = '{2'b01, 8'hC1, 8'h77, 8'hA6, 0, 16'hA6C1, 8'hA6};
    vt[4] = '{2'b01, 8'h80, 8'h00, 8'h3C, 0, 16'h3C80, 8'h3C};
    vt[5] = '{2'b10, 8'h85, 8'h5A, 8'h00, 0, 16'h5A85, 8'h3C};

    // Reset state
    #23;
    check("rst_done", {31'h0, Done_Sig}, 32'h0);
    check("rst_read_data", {24'h0, Read_Data}, 32'h0);
    check("rst_ce", {31'h0, DS_RST}, 32'h0);
    check("rst_sclk", {31'h0, DS_SCLK}, 32'h0);
    check("rst_sio_z", {31'h0, (DS_SIO === 1'bz)}, 32'h1);
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (3) @(negedge CLK);

    for (int i = 0; i < 3; i++) run_txn(vt[i], i);

    // Illegal request 2'b11 is ignored.
    hi = 0; dn = 0;
    Start_Sig = 2'b11;
    Words_Addr = 8'h84;
    repeat (20) begin
      @(negedge CLK);
      if (DS_RST) hi++;
      if (Done_Sig) dn++;
    end
    Start_Sig = 2'b00;
    repeat (4) @(negedge CLK);
    check("illegal_ce_cycles", hi, 0);
    check("illegal_done", dn, 0);

    for (int i = 3; i < 6; i++) run_txn(vt[i], i);

    // Reset during pulse 5 of a read.
    slave_en = 1'b1; slave_byte = 8'h59;
    Start_Sig = 2'b01; Words_Addr = 8'h81;
    cyc = 0; nr = 0; prev = DS_SCLK;
    while (nr < 5 && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (DS_SCLK && !prev) nr++;
      prev = DS_SCLK;
    end
    check("midrst_reached_pulse5", nr, 5);
    RSTn = 1'b0;
    #1;
    check("midrst_ce", {31'h0, DS_RST}, 32'h0);
    check("midrst_sclk", {31'h0, DS_SCLK}, 32'h0);
    check("midrst_sio_z", {31'h0, (DS_SIO === 1'bz)}, 32'h1);
    check("midrst_read_data", {24'h0, Read_Data}, 32'h0);
    repeat (3) @(negedge CLK);
    Start_Sig = 2'b00;
    RSTn = 1'b1;
    hi = 0; dn = 0;
    repeat (100) begin
      @(negedge CLK);
      if (DS_RST) hi++;
      if (Done_Sig) dn++;
    end
    check("midrst_no_done", dn, 0);
    check("midrst_no_ce", hi, 0);

    // Back-to-back reads with Start held through Done.
    slave_en = 1'b1; slave_byte = 8'h59; contention = 0;
    Start_Sig = 2'b01; Words_Addr = 8'h81;
    cyc = 0; seen = 0;
    while (!seen && cyc < 400) begin
      @(negedge CLK);
      cyc++;
      if (Done_Sig) seen = 1;
    end
    check("b2b_first_done", {31'h0, seen}, 32'h1);
    check("b2b_first_read", {24'h0, Read_Data}, 32'h59);
    lo = 1; cyc = 0;
    @(negedge CLK);
    while (!DS_RST && cyc < 50) begin
      lo++;
      cyc++;
      @(negedge CLK);
    end
    check("b2b_restarted", {31'h0, DS_RST}, 32'h1);
    check("b2b_gap_ge_tcwh", {31'h0, (lo >= 4)}, 32'h1);
    slave_byte = 8'hC3;
    cyc = 0; seen = 0;
    while (!seen && cyc < 400) begin
      @(negedge CLK);
      cyc++;
      if (Done_Sig) seen = 1;
    end
    Start_Sig = 2'b00;
    check("b2b_second_done", {31'h0, seen}, 32'h1);
    check("b2b_second_read", {24'h0, Read_Data}, 32'hC3);
    repeat (12) @(negedge CLK);
    check("b2b_contention", contention, 0);
    check("sio_z_when_ce_low", zviol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ds1302_serial_access.md
Name: ds1302_serial_access

Overview:
Bit-level DS1302 serial engine, directly downstream of the DS1302 command control stage.
- Takes a one-shot access request: direction, command/address byte and write byte.
- Drives the DS1302 three-wire bus (CE, SCLK, SIO).
- Returns a one-cycle done pulse and, for reads, the received byte.
- Owns all bus timing; upstream sees only a Start/Done handshake.

Parameters:
T_HALF, 50, CLK cycles per SCLK half-period (50 MHz CLK -> 500 kHz SCLK); legal range 2 or more.
T_CE, 200, CLK cycles of CE setup before first SCLK rise and CE hold after last SCLK fall; legal range 1 or more.
T_CWH, 200, CLK cycles CE held low after a transaction before the next may begin; legal range 1 or more.

Ports:
CLK  in  1  system clock; all logic on rising edge
RSTn  in  1  asynchronous active-low reset
Start_Sig  in  2  2'b10 write request, 2'b01 read request; held by upstream until Done_Sig
Words_Addr  in  8  DS1302 command byte, shifted verbatim LSB first
Write_Data  in  8  data byte for writes
Done_Sig  out  1  one-CLK pulse at transaction end
Read_Data  out  8  byte received on the last read
DS_RST  out  1  DS1302 CE pin, active high
DS_SCLK  out  1  DS1302 serial clock
DS_SIO  inout  1  DS1302 bidirectional data pin

Behaviour:
Clock and reset:
- Reset is RSTn, asynchronous, active-low; clock is CLK.
- Reset values: Done_Sig=0, Read_Data=8'h00, DS_RST=0, DS_SCLK=0, DS_SIO high-Z, state=IDLE, all counters 0.

States: IDLE -> CE_SETUP -> SHIFT -> CE_HOLD -> DONE -> RECOVER -> IDLE.
- IDLE:
  - Start_Sig==2'b10 or 2'b01: latch Words_Addr, Write_Data and direction; raise DS_RST; go to CE_SETUP.
  - Start_Sig 2'b00 or 2'b11: no action (2'b11 is illegal and is ignored).
- CE_SETUP: wait T_CE cycles, SCLK low, then go to SHIFT.
- SHIFT: 16 SCLK pulses, bit index 0..15. Each pulse is T_HALF cycles low, then T_HALF cycles high.
  - Bits 0-7: drive the latched address LSB first, valid for the whole pulse.
  - Write, bits 8-15: drive Write_Data LSB first.
  - Read: release SIO (high-Z) on the falling SCLK edge that ends pulse 7. Data bit k is sampled on the last CLK of the low phase of pulse 8+k, into a shift register LSB first.
  - After pulse 15 falls, go to CE_HOLD.
- CE_HOLD: T_CE cycles with SCLK low; then drop DS_RST and release SIO.
- DONE: Done_Sig=1 for exactly one cycle. On a read, Read_Data is updated before or in the same cycle as Done_Sig.
- RECOVER: DS_RST low for T_CWH cycles, then go to IDLE.

Latency: Done_Sig rises exactly 2*T_CE + 32*T_HALF + 1 cycles after the IDLE cycle that sampled Start_Sig.

Read_Data:
- Holds its value until the next read's DONE.
- Writes never alter it.

SIO drive rules:
- Driven only in SHIFT during address bits and write-data bits.
- High-Z in all other states.
- Never driven while a read-data bit is being sampled.

Boundary conditions:
- Start_Sig dropped or changed mid-transaction: ignored; the transaction completes on the latched values.
- Start_Sig still asserted on return to IDLE: a new transaction starts (back-to-back requests are legal).
- RSTn asserted mid-transaction: bus returns to reset values immediately, no Done_Sig is issued, and Read_Data is cleared.
- Direction comes only from Start_Sig. Words_Addr bit 0 is not checked against it.

Optional Feature:
Macro DS1302_SIO_SPLIT_EN.
- Defined: DS_SIO is removed and replaced by three ports.
  - DS_SIO_O, out 1, data to drive.
  - DS_SIO_OE, out 1, high when driving.
  - DS_SIO_I, in 1, data sampled from the pin.
  - The tri-state buffer lives outside the block, for pad-ring or simulation use.
  - Timing and values are identical to the inout build; DS_SIO_OE=1 exactly where the inout build drives, 0 elsewhere.
- Undefined: single inout DS_SIO with an internal tri-state buffer.

Test Plan:
- All scenarios use T_HALF=2, T_CE=4, T_CWH=4.
- Write: Start_Sig=2'b10, Words_Addr=8'h84, Write_Data=8'h23 -> SIO bits at the 16 rising SCLK edges are 0,0,1,0,0,0,0,1,1,1,0,0,0,1,0,0. Done_Sig is one cycle wide, 73 cycles after start; DS_RST high for exactly 72 cycles; Read_Data unchanged.
- Read: Start_Sig=2'b01, Words_Addr=8'h81, slave model drives 8'h59 LSB first on falling edges after pulse 7 -> Read_Data=8'h59 at Done_Sig, and no bus contention is flagged by the model.
- Illegal and early-release: Start_Sig=2'b11 for 20 cycles -> DS_RST stays 0, no Done_Sig. Then Start_Sig=2'b10 dropped after 3 cycles -> full 16-pulse write still completes with Done_Sig.
- Reset mid-shift: RSTn low during pulse 5 of a read -> DS_RST=0, DS_SCLK=0, SIO high-Z, Read_Data=8'h00 in that cycle; no Done_Sig after release.
- Back-to-back: Start_Sig held at 2'b01 through Done_Sig -> second transaction's DS_RST rises no earlier than T_CWH=4 cycles after the first's DS_RST falls.
